// File: rtl/bank_stream_reader.sv
// bank_stream_reader: streams a burst of words out of a synchronous-read
// memory bank through a 2-entry output FIFO with valid/ready handshake.
//
// A burst is requested with start in IDLE. The reader issues bank reads
// (rd_en/rd_addr/rd_muxcode). Each rd_word is captured one cycle after its
// read and presented on out_word/out_valid. Reads are throttled so that the
// FIFO plus the read in flight never exceeds two words. With out_ready held
// high this sustains one word per cycle.
//
// Optional feature: define BANK_READER_STRIDE_EN to add a 'stride' input
// that is sampled with start and used as the address step. Without it the
// step is fixed at 1. Addresses always wrap modulo 2^a.
module bank_stream_reader #(
  parameter int w = 64,
  parameter int a = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [a-1:0] base_addr,
  input  logic [a:0]   length,
  input  logic [1:0]   muxcode,
`ifdef BANK_READER_STRIDE_EN
  input  logic [a-1:0] stride,
`endif
  output logic         busy,
  output logic         done,
  output logic         rd_en,
  output logic [a-1:0] rd_addr,
  output logic [1:0]   rd_muxcode,
  input  logic [w-1:0] rd_word,
  output logic [w-1:0] out_word,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [a:0] ONE_WORD = {{a{1'b0}}, 1'b1};

  // Control state
  state_t       state_q, state_d;
  logic [a:0]   issue_rem_q, issue_rem_d;  // reads still to issue
  logic [a:0]   xfer_rem_q, xfer_rem_d;    // words still to hand to the consumer
  logic [a-1:0] next_addr_q, next_addr_d;  // address of the next read
  logic [a-1:0] last_addr_q, last_addr_d;  // address of the most recent read
  logic [1:0]   mux_q, mux_d;
  logic         inflight_q, inflight_d;    // a read was issued last cycle
  logic [a-1:0] step;

`ifdef BANK_READER_STRIDE_EN
  logic [a-1:0] step_q, step_d;
  assign step = step_q;
`else
  assign step = {{(a-1){1'b0}}, 1'b1};
`endif

  // Output FIFO
  logic [w-1:0] fifo_mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Per-cycle handshake and issue decisions
  logic         launch;
  logic         fifo_valid;
  logic         push;
  logic         pop;
  logic [2:0]   occupancy;
  logic         issue;

  // Decide this cycle's launch, push, pop and read issue from registered state
  always_comb begin
    launch     = (state_q == IDLE) && start;
    fifo_valid = (count_q != 2'd0);
    push       = inflight_q;
    pop        = fifo_valid && out_ready;
    // Words that will occupy FIFO slots after this edge if nothing new is
    // issued: stored words plus the returning read, minus the one leaving.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == RUN) && (issue_rem_q != '0) && (occupancy < 3'd2);
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop && (xfer_rem_q == ONE_WORD)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: capture request, advance address and counters
  always_comb begin
    issue_rem_d = issue_rem_q;
    xfer_rem_d  = xfer_rem_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    mux_d       = mux_q;
    inflight_d  = issue;
`ifdef BANK_READER_STRIDE_EN
    step_d      = step_q;
`endif

    if (launch) begin
      issue_rem_d = length;
      xfer_rem_d  = length;
      next_addr_d = base_addr;
      mux_d       = muxcode;
`ifdef BANK_READER_STRIDE_EN
      step_d      = stride;
`endif
    end

    if (issue) begin
      issue_rem_d = issue_rem_q - 1'b1;
      next_addr_d = next_addr_q + step;   // wraps modulo 2^a
      last_addr_d = next_addr_q;
    end

    if (pop) begin
      xfer_rem_d = xfer_rem_q - 1'b1;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      issue_rem_q <= '0;
      xfer_rem_q  <= '0;
      next_addr_q <= '0;
      last_addr_q <= '0;
      mux_q       <= '0;
      inflight_q  <= 1'b0;  // drops any read issued just before reset
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
`ifdef BANK_READER_STRIDE_EN
      step_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      xfer_rem_q  <= xfer_rem_d;
      next_addr_q <= next_addr_d;
      last_addr_q <= last_addr_d;
      mux_q       <= mux_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef BANK_READER_STRIDE_EN
      step_q      <= step_d;
`endif
    end
  end

  // FIFO storage: capture the bank word returning from last cycle's read
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count_q qualifies its contents
    // and out_word is forced to zero whenever the FIFO is empty.
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= rd_word;
    end
  end

  // Outputs are held at zero while reset is asserted
  assign busy       = !rst && (state_q != IDLE);
  assign done       = !rst && (state_q == DONE);
  assign rd_en      = !rst && issue;
  assign rd_addr    = rst ? '0 : (issue ? next_addr_q : last_addr_q);
  assign rd_muxcode = rst ? 2'b00 : mux_q;
  assign out_valid  = !rst && fifo_valid;
  assign out_word   = out_valid ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_bank_stream_reader.sv
// Self-checking bench for bank_stream_reader. A behavioural bank returns
// rd_word one cycle after rd_en. A reference model expands each accepted
// burst into the list of addresses and words it must produce, then checks
// the DUT's reads, stream, handshake stability and done/busy timing.
// Define BANK_READER_STRIDE_EN to also exercise the stride port.
module tb_bank_stream_reader;

  localparam int W     = 64;
  localparam int A     = 10;
  localparam int LW    = A + 1;
  localparam int DEPTH = 1 << A;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [A-1:0] base_addr;
  logic [A:0]   length;
  logic [1:0]   muxcode;
`ifdef BANK_READER_STRIDE_EN
  logic [A-1:0] stride;
  logic [A-1:0] cfg_stride = 1;
`endif
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [1:0]   rd_muxcode;
  logic [W-1:0] rd_word;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready;

  bank_stream_reader #(.w(W), .a(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .muxcode    (muxcode),
`ifdef BANK_READER_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_muxcode (rd_muxcode),
    .rd_word    (rd_word),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural bank: registered read, garbage when not reading
  logic [W-1:0] bank [DEPTH];
  always @(posedge clk) rd_word <= rd_en ? bank[rd_addr] : {$urandom, $urandom};

  // Reference model state
  logic [A-1:0] exp_addr [$];
  logic [W-1:0] exp_word [$];
  int           cyc = 0;
  int           start_cyc = 0;
  int           done_due = -1;
  bit           model_busy = 1'b0;
  bit           mon_en = 1'b0;
  logic [A-1:0] model_last = '0;
  logic [1:0]   model_mux = '0;
  int           issued = 0;
  int           xferred = 0;
  bit           seen_rd = 1'b1;
  bit           seen_valid = 1'b1;
  bit           burst_live = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the DUT against the model once per cycle, mid-cycle
  always @(negedge clk) begin
    bit xfer;
    bit exp_done;
    int outstanding;
    if (mon_en) begin
      xfer        = out_valid && out_ready;
      exp_done    = (cyc == done_due);
      outstanding = issued - xferred;

      check("rd_mux", 64'(rd_muxcode), 64'(model_mux));
      if (rd_en) begin
        // buffered plus in-flight words, after this cycle's transfer, must leave room
        check("rd_room", 64'((outstanding - int'(xfer)) < 2), 64'd1);
        if (!seen_rd) begin
          check("first_rd_cycle", 64'(cyc - start_cyc), 64'd1);
          seen_rd = 1'b1;
        end
        if (exp_addr.size() == 0) begin
          check("extra_rd", 64'd1, 64'd0);
        end else begin
          check("rd_addr", 64'(rd_addr), 64'(exp_addr[0]));
          model_last = exp_addr.pop_front();
        end
        issued++;
      end else begin
        check("rd_addr_hold", 64'(rd_addr), 64'(model_last));
      end

      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_word", out_word, stall_word);
      end

      if (!seen_valid && out_valid) begin
        check("first_valid_cycle", 64'(cyc - start_cyc), 64'd3);
        seen_valid = 1'b1;
      end

      if (xfer) begin
        if (exp_word.size() == 0) begin
          check("extra_word", 64'd1, 64'd0);
        end else begin
          check("out_word", out_word, exp_word.pop_front());
          xferred++;
          if (exp_word.size() == 0 && burst_live) begin
            done_due   = cyc + 1;
            burst_live = 1'b0;
          end
        end
      end

      check("done", 64'(done), 64'(exp_done));
      check("busy", 64'(busy), 64'(model_busy));
      if (exp_done) model_busy = 1'b0;

      stall_prev = out_valid && !out_ready;
      stall_word = out_word;
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 1;            // 1,0,0,1,0,0,...
      default: return $urandom_range(0, 9) < 6;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      64'(busy),       64'd0);
    check({tag, "_done"},      64'(done),       64'd0);
    check({tag, "_rd_en"},     64'(rd_en),      64'd0);
    check({tag, "_out_valid"}, 64'(out_valid),  64'd0);
    check({tag, "_rd_addr"},   64'(rd_addr),    64'd0);
    check({tag, "_rd_mux"},    64'(rd_muxcode), 64'd0);
    check({tag, "_out_word"},  out_word,        64'd0);
  endtask

  // Present a request for one cycle and expand it into the model's lists
  task automatic launch(input logic [A-1:0] base, input int len, input logic [1:0] mux);
    int step;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    length    = LW'(len);
    muxcode   = mux;
`ifdef BANK_READER_STRIDE_EN
    stride    = cfg_stride;
    step      = int'(cfg_stride);
`else
    step      = 1;
`endif
    start_cyc = cyc;
    @(posedge clk); #1;
    // scramble request inputs so late sampling would be visible
    start     = 1'b0;
    base_addr = A'($urandom);
    length    = LW'($urandom_range(1, 15));
    muxcode   = 2'($urandom);
`ifdef BANK_READER_STRIDE_EN
    stride    = A'($urandom);
`endif
    exp_addr.delete();
    exp_word.delete();
    for (int i = 0; i < len; i++) begin
      int ad;
      ad = (int'(base) + i * step) % DEPTH;
      exp_addr.push_back(A'(ad));
      exp_word.push_back(bank[ad]);
    end
    model_mux  = mux;
    model_busy = 1'b1;
    issued     = 0;
    xferred    = 0;
    seen_rd    = (len == 0);
    seen_valid = (len == 0);
    burst_live = (len > 0);
    done_due   = (len == 0) ? cyc : -1;
  endtask

  // Run a burst to completion; poke_at re-asserts start in that burst cycle
  task automatic run_burst(input logic [A-1:0] base, input int len, input logic [1:0] mux,
                           input int mode, input int poke_at);
    int k;
    bit got;
    out_ready = ready_for(mode, 0);
    launch(base, len, mux);
    k         = 1;
    out_ready = ready_for(mode, k);
    start     = (poke_at == k);
    got       = 1'b0;
    while (!got && k < len * 8 + 20) begin
      @(negedge clk);
      got = done;
      @(posedge clk); #1;
      k++;
      out_ready = ready_for(mode, k);
      start     = (poke_at == k);
    end
    start = 1'b0;
    if (!got) check("burst_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("after_busy", 64'(busy), 64'd0);
    check("after_done", 64'(done), 64'd0);
  endtask

  task automatic reset_mid_burst();
    int k;
    out_ready = 1'b1;
    launch(A'($urandom), 16, 2'b11);
    k = 0;
    @(negedge clk); #1;
    while (issued < 3 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    if (issued < 3) check("rst_wait_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr.delete();
    exp_word.delete();
    model_busy = 1'b0;
    done_due   = -1;
    burst_live = 1'b0;
    model_last = '0;
    model_mux  = '0;
    stall_prev = 1'b0;
    seen_rd    = 1'b1;
    seen_valid = 1'b1;
    @(negedge clk);
    check_zero("after_rst");
    #1 mon_en = 1'b1;
    // any stale word, read or done pulse now shows up as a model mismatch
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) bank[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; muxcode = '0; out_ready = 1'b0;
`ifdef BANK_READER_STRIDE_EN
    stride = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("in_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_rst");
    #1 mon_en = 1'b1;

    // Basic burst, full throughput
    run_burst(10'h010, 4, 2'b01, 0, 0);
    // Address wrap at the top of the bank
    run_burst(10'h3FE, 4, 2'b10, 0, 0);
    // Backpressure 1,0,0 with an ignored start mid-burst
    run_burst(A'($urandom), 8, 2'b11, 1, 3);
    // Zero-length burst with start pulsed during the DONE cycle
    run_burst(A'($urandom), 0, 2'b01, 0, 1);
    // Reset in the cycle after the third read, then a clean burst
    reset_mid_burst();
    run_burst(A'($urandom), 16, 2'b10, 0, 0);
    // Maximum length covers the whole bank once
    run_burst(A'($urandom), DEPTH, 2'b01, 0, 0);

`ifdef BANK_READER_STRIDE_EN
    cfg_stride = 10'h004;
    run_burst(10'h100, 3, 2'b00, 0, 0);
    cfg_stride = 10'h000;
    run_burst(10'h155, 3, 2'b11, 1, 0);
`endif

    for (int n = 0; n < 12; n++) begin
      logic [A-1:0] b;
      b = (n % 3 == 0) ? A'(DEPTH - 1 - $urandom_range(0, 3)) : A'($urandom);
`ifdef BANK_READER_STRIDE_EN
      cfg_stride = A'($urandom_range(0, 7));
`endif
      run_burst(b, $urandom_range(0, 24), 2'($urandom), $urandom_range(0, 2), 0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
